// File: rtl/result_buffer.sv
// Captures skewed result rows from the bottom edge of the systolic array, deskews them,
// stores one tile of ROWS rows, then streams the tile out row by row over valid/ready.
module result_buffer #(
  parameter int WIDTH   = 4,
  parameter int OUTSIZE = 16,
  parameter int ROWS    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH*OUTSIZE-1:0] in_result,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*OUTSIZE-1:0] out_result,
  output logic                     out_last,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  // Handshake: a row transfers on any cycle where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_result/out_last hold. in_ready is
  // advisory only: a column-0 beat is taken iff in_valid && in_ready.

  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]            acc_cnt;
  logic [CW-1:0]            wr_cnt;
  logic [PW-1:0]            rd_ptr;
  logic [WIDTH-2:0]         acc_pipe;
  logic [WIDTH*OUTSIZE-1:0] aligned_row;
  logic [WIDTH*OUTSIZE-1:0] mem [ROWS];

  logic accept;
  logic write_row;
  logic last_write;
  logic handshake;
  logic drain_done;

  // Lane i is delayed WIDTH-1-i cycles so all lanes of a row line up with lane WIDTH-1.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    localparam int D = WIDTH - 1 - gi;
    if (D == 0) begin : g_live
      assign aligned_row[gi*OUTSIZE +: OUTSIZE] = in_result[gi*OUTSIZE +: OUTSIZE];
    end else begin : g_dly
      logic [OUTSIZE-1:0] dly [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dly[k] <= '0;
        end else begin
          dly[0] <= in_result[gi*OUTSIZE +: OUTSIZE];
          for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
        end
      end
      assign aligned_row[gi*OUTSIZE +: OUTSIZE] = dly[D-1];
    end
  end

  assign in_ready   = (state != DRAIN) && (acc_cnt < CW'(ROWS));
  assign accept     = in_valid && in_ready;
  assign write_row  = acc_pipe[WIDTH-2] && (state == COLLECT);
  assign last_write = write_row && (wr_cnt == CW'(ROWS - 1));
  assign out_valid  = (state == DRAIN);
  assign out_last   = out_valid && (rd_ptr == PW'(ROWS - 1));
  assign out_result = out_valid ? mem[rd_ptr] : '0;
  assign handshake  = out_valid && out_ready;
  assign drain_done = handshake && out_last;
  assign dbg_state  = state;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = COLLECT;
      COLLECT: if (last_write) state_n = DRAIN;
      DRAIN:   if (drain_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      acc_pipe <= '0;
      overflow <= 1'b0;
    end else begin
      state       <= state_n;
      acc_pipe[0] <= accept;
      for (int k = 1; k < WIDTH - 1; k++) acc_pipe[k] <= acc_pipe[k-1];
      if (in_valid && !in_ready) overflow <= 1'b1;

      if (drain_done) begin
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (accept && (acc_cnt < CW'(ROWS))) acc_cnt <= acc_cnt + 1'b1;
        if (write_row && (wr_cnt < CW'(ROWS))) wr_cnt <= wr_cnt + 1'b1;
      end

      if (last_write) rd_ptr <= '0;
      else if (handshake) rd_ptr <= out_last ? '0 : rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: counters gate every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (write_row) mem[wr_cnt[PW-1:0]] <= aligned_row;
  end

endmodule

// File: tb/tb_result_buffer.sv
// Directed scenarios with random row data for result_buffer; expected rows come from
// a queue of the rows the bench intends to be accepted, in arrival order.
module tb_result_buffer;

  localparam int WIDTH   = 4;
  localparam int OUTSIZE = 16;
  localparam int ROWS    = 4;
  localparam int W       = WIDTH * OUTSIZE;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_result;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_last;
  logic         overflow;
  logic [1:0]   dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  int           beat_at[$];
  logic [W-1:0] rows[$];
  logic [W-1:0] exp_q[$];

  result_buffer #(.WIDTH(WIDTH), .OUTSIZE(OUTSIZE), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_last(out_last), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_row();
    return {$urandom, $urandom};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_out_result"}, out_result, W'(0));
    chk({tag, "_out_last"}, W'(out_last), W'(0));
    chk({tag, "_overflow"}, W'(overflow), W'(0));
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_state"}, W'(dbg_state), W'(0));
  endtask

  // Drive the cycle-c slice of every row in beat_at/rows, skewed so lane i of a row
  // whose column-0 beat is at cycle s appears at cycle s+i.
  task automatic drive_cycle(input int c);
    in_valid  = 1'b0;
    in_result = rand_row();
    foreach (beat_at[j]) begin
      if (beat_at[j] == c) in_valid = 1'b1;
      for (int i = 0; i < WIDTH; i++)
        if (beat_at[j] + i == c) in_result[i*OUTSIZE +: OUTSIZE] = rows[j][i*OUTSIZE +: OUTSIZE];
    end
  endtask

  // rmode 0: out_ready always 1; rmode 1: out_ready high every third cycle.
  task automatic run_scenario(input string tag, input int n, input int rmode, input int exp_rise);
    int hs   = 0;
    int rise = -1;
    for (int c = 0; c < n; c++) begin
      drive_cycle(c);
      out_ready = (rmode == 0) ? 1'b1 : ((c % 3) == 0);
      if (out_valid) begin
        if (rise < 0) rise = c;
        if (exp_q.size() > 0) begin
          chk({tag, "_row"}, out_result, exp_q[0]);
          chk({tag, "_last"}, W'(out_last), W'(hs == ROWS - 1));
        end
        if (out_ready) begin
          hs++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_rise_cycle"}, W'(rise), W'(exp_rise));
    chk({tag, "_handshakes"}, W'(hs), W'(ROWS));
    chk({tag, "_end_state"}, W'(dbg_state), W'(0));
    chk({tag, "_end_valid"}, W'(out_valid), W'(0));
    chk({tag, "_end_in_ready"}, W'(in_ready), W'(1));
  endtask

  task automatic setup_tile(input int s0, input int s1, input int s2, input int s3, input bit pattern);
    logic [W-1:0] r;
    beat_at = {s0, s1, s2, s3};
    rows.delete();
    exp_q.delete();
    for (int k = 0; k < ROWS; k++) begin
      if (pattern) for (int i = 0; i < WIDTH; i++) r[i*OUTSIZE +: OUTSIZE] = OUTSIZE'(k * 16 + i);
      else r = rand_row();
      rows.push_back(r);
      exp_q.push_back(r);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    out_ready = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Single tile with patterned data, consumer always ready.
    setup_tile(0, 1, 2, 3, 1'b1);
    run_scenario("single", 14, 0, 7);
    chk("single_overflow", W'(overflow), W'(0));
    step();

    // Back-pressure with random data.
    setup_tile(0, 1, 2, 3, 1'b0);
    run_scenario("backpress", 25, 1, 7);
    step();

    // Fifth beat arrives while draining: dropped, overflow latches.
    setup_tile(0, 1, 2, 3, 1'b1);
    beat_at.push_back(8);
    rows.push_back(rand_row());
    run_scenario("overflow", 16, 0, 7);
    chk("overflow_set", W'(overflow), W'(1));
    step();

    // Gapped beats; overflow stays sticky without reset.
    setup_tile(0, 2, 5, 6, 1'b0);
    run_scenario("gapped", 17, 0, 10);
    chk("overflow_sticky", W'(overflow), W'(1));
    step();

    // Two rows written, then reset discards them.
    setup_tile(0, 1, 2, 3, 1'b0);
    beat_at = {0, 1};
    for (int c = 0; c < 7; c++) begin
      drive_cycle(c);
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    step();
    check_reset_outputs("midreset");
    rst = 1'b0;
    step();

    setup_tile(0, 1, 2, 3, 1'b0);
    run_scenario("after_reset", 14, 0, 7);
    chk("after_reset_overflow", W'(overflow), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
